// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that passes on only the command characters 'T' and 'D'.
// An accepted command is presented as a held byte plus a one-cycle strobe.
module uart_cmd_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    input  logic       ready_to_act,
    output logic [7:0] cmd_byte,
    output logic       valid_command,
    output logic       cmd_rejected,
    output logic       frame_error,
    output logic       rx_busy
);

    // CLKS_PER_BIT must be at least 8.
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int TW           = $clog2(CLKS_PER_BIT);

    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    localparam logic [7:0] CMD_T = 8'h54;
    localparam logic [7:0] CMD_D = 8'h44;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      cmd_byte_q, cmd_byte_d;
    logic            valid_q, valid_d;
    logic            rejected_q, rejected_d;
    logic            frame_err_q, frame_err_d;
    logic            rx_meta_q, rx_meta_d;
    logic            rx_s_q, rx_s_d;
    logic            is_cmd;

    assign is_cmd = (shift_q == CMD_T) || (shift_q == CMD_D);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        rx_meta_d   = rx_serial;
        rx_s_d      = rx_meta_q;
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        cmd_byte_d  = cmd_byte_q;
        valid_d     = 1'b0;
        rejected_d  = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                end
            end
            S_START: begin
                if (tick_cnt_q == TICK_MID) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_DATA;
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + TICK_ONE;
                end
            end
            S_DATA: begin
                if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d = '0;
                    shift_d    = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + TICK_ONE;
                end
            end
            S_STOP: begin
                if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d = '0;
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end else if (is_cmd && ready_to_act) begin
                        cmd_byte_d = shift_q;
                        valid_d    = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        rejected_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + TICK_ONE;
                end
            end
            S_WAIT_HIGH: begin
                // A held-low line (break) must not look like a fresh start bit.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop updates from pre-edge values.
        if (!rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            cmd_byte_q  <= '0;
            valid_q     <= 1'b0;
            rejected_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            cmd_byte_q  <= cmd_byte_d;
            valid_q     <= valid_d;
            rejected_q  <= rejected_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign cmd_byte      = cmd_byte_q;
    assign valid_command = valid_q;
    assign cmd_rejected  = rejected_q;
    assign frame_error   = frame_err_q;
    assign rx_busy       = (state_q != S_IDLE);

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

UART receive front-end for the sensor crossbar. It deserializes 8N1 frames from the board's RX pin and filters them down to the two recognised command characters, 'T' (8'h54) and 'D' (8'h44). It presents an accepted command to the crossbar as a byte plus a one-cycle `valid_command` strobe. It sits directly upstream of the crossbar and drives its `uart_rx` and `valid_command` inputs.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `CLKS_PER_BIT`, CLK_FREQ/BAUD (derived localparam, integer division): clocks per bit. Must be ≥ 8.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `rst`  in  1: reset, synchronous, active-low.
- `rx_serial`  in  1: asynchronous serial line; idle is high.
- `ready_to_act`  in  1: crossbar can take a new command.
- `cmd_byte`  out  8: last accepted command; connects to crossbar `uart_rx`.
- `valid_command`  out  1: 1-cycle strobe marking a new `cmd_byte`.
- `cmd_rejected`  out  1: 1-cycle strobe for a good frame that was not accepted.
- `frame_error`  out  1: 1-cycle strobe when the stop bit is sampled low.
- `rx_busy`  out  1: high in every state except IDLE.

## Operation
- Input path: `rx_serial` passes through a 2-FF synchronizer; the synchronized signal is `rx_s`. All decisions use `rx_s`.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- Bit timer `tick_cnt` counts 0..CLKS_PER_BIT-1. Bit index `bit_idx` counts 0..7.
- IDLE: on `rx_s`==0, go to START and clear `tick_cnt`.
- START: at `tick_cnt`==CLKS_PER_BIT/2-1 (mid start bit), sample the line.
  - If `rx_s`==1: false start; return to IDLE with no strobes.
  - Else: clear `tick_cnt` and `bit_idx`; go to DATA.
- DATA: at each `tick_cnt`==CLKS_PER_BIT-1 (mid data bit), shift `rx_s` into the shift register MSB and right-shift, so bits arrive LSB first.
  - After `bit_idx`==7 is sampled, go to STOP.
- STOP: at mid stop bit (`tick_cnt`==CLKS_PER_BIT-1), evaluate the frame and take exactly one action:
  - `rx_s`==1, byte ∈ {8'h54, 8'h44}, `ready_to_act`==1: load `cmd_byte`; pulse `valid_command`; go to IDLE.
  - `rx_s`==1, any other byte, or `ready_to_act`==0: pulse `cmd_rejected`; `cmd_byte` unchanged; go to IDLE.
  - `rx_s`==0: pulse `frame_error`; byte discarded; go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. This covers break conditions and prevents a false restart.
- `cmd_byte` holds its value until the next accepted command.
- `valid_command`, `cmd_rejected` and `frame_error` are mutually exclusive. Each lasts exactly one cycle.
- Lowercase 't'/'d', CR and LF are all rejected.

## Timing
- Reset values (on the `clk` edge while `rst`==0): FSM=IDLE, `cmd_byte`=8'h00, all strobes 0, `rx_busy`=0, counters 0, synchronizer FFs=1 (idle line).
- Reset mid-frame aborts immediately. No strobe is generated for the aborted frame.
- Latency: the strobe is registered and appears 1 cycle after the mid-stop sample. From the `rx_serial` falling edge this is about 2 + 9.5·CLKS_PER_BIT cycles; exact value ±1 cycle.
- Return to IDLE happens at mid stop bit. A start bit beginning at the nominal end of the stop bit is still detected, so back-to-back frames are supported.
- `valid_command` is not held. The crossbar samples `cmd_byte` in the same cycle as the strobe; `cmd_byte` is already stable during that cycle.
- `ready_to_act` is sampled only in the mid-stop cycle.
  - If it rises later, the frame is not replayed.
  - If it drops after acceptance, there is no effect on this block.
- `rx_busy` goes high 1 cycle after the start is detected in IDLE. It goes low on entering IDLE.

## Test plan
Bench parameters: CLK_FREQ=1_600_000, BAUD=100_000, so CLKS_PER_BIT=16.
- Accepted command: `ready_to_act`=1, send 8'h54 → one `valid_command` pulse, `cmd_byte`=8'h54, no other strobes. Then send 8'h44 → `cmd_byte`=8'h44.
- Filtering: send 8'h41 and 8'h74 → `cmd_rejected` pulses once per frame; `cmd_byte` stays 8'h44; `valid_command` stays 0.
- Busy crossbar: `ready_to_act`=0, send 8'h54 → `cmd_rejected`=1 for one cycle; `cmd_byte` unchanged.
- Framing and glitches:
  - Send 8'h54 with stop bit=0 → `frame_error` pulse; line held low 40 bit times → no further strobes.
  - After the line returns high, send 8'h44 → accepted.
  - A 4-cycle low glitch → no strobes; `rx_busy` returns to 0.
- Throughput and reset:
  - Two back-to-back frames 8'h54 then 8'h44 with zero idle → two `valid_command` pulses, each matching its byte.
  - `rst`=0 asserted during DATA bit 3 → all outputs at reset values on the next edge; the next clean frame is accepted.
